// File: rtl/fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_prefetch_unit
//  Description : LC3 fetch stage. Generates pc/npc, issues one instruction
//                memory read at a time and buffers returned instructions in
//                a DEPTH-entry prefetch FIFO for decode. Branch redirects
//                flush the FIFO and squash an in-flight read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       INSTR_W  = 16,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h3000
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_fetch_i,
    input  logic                     enable_updatePC_i,
    input  logic                     br_taken_i,
    input  logic [ADDR_W-1:0]        taddr_i,
    output logic                     instrmem_rd_o,
    output logic [ADDR_W-1:0]        imem_addr_o,
    input  logic                     imem_valid_i,
    input  logic [INSTR_W-1:0]       imem_rdata_i,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [ADDR_W-1:0]        npc_o,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
    output logic [INSTR_W-1:0]       dout_instr_o,
    output logic [ADDR_W-1:0]        dout_pc_o,
    output logic [ADDR_W-1:0]        dout_npc_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int unsigned          c_ptr_w    = $clog2(DEPTH);
    localparam int unsigned          c_cnt_w    = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]   c_full     = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0]   c_last     = c_cnt_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0]   c_ptr_one  = c_ptr_w'(1);
    localparam logic [ADDR_W-1:0]    c_addr_one = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // no read outstanding
        ST_WAIT  = 2'd1,   // one read outstanding
        ST_DRAIN = 2'd2    // outstanding read squashed, response to be dropped
    } state_t;

    state_t               state_q,  state_d;
    logic [ADDR_W-1:0]    pc_q,     pc_d;
    logic [ADDR_W-1:0]    req_pc_q, req_pc_d;   // address of the outstanding read
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q,  count_d;

    logic [INSTR_W-1:0]   fifo_instr_q [DEPTH];
    logic [ADDR_W-1:0]    fifo_pc_q    [DEPTH];

    logic                 w_dout_valid;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_room;
    logic                 w_issue;

    // Handshake terms. A new read reserves a FIFO slot up front so its
    // response always has somewhere to land; holding reset blocks requests.
    always_comb begin
        w_dout_valid = (count_q != '0);
        w_push       = (state_q == ST_WAIT) && imem_valid_i && !br_taken_i;
        w_pop        = w_dout_valid && dout_ready_i && !br_taken_i;
        w_room       = (count_q < c_last) || ((count_q == c_last) && !w_push) || w_pop;
        w_issue      = !reset_i && enable_fetch_i && enable_updatePC_i && w_room && !br_taken_i
                       && ((state_q == ST_IDLE) || ((state_q == ST_WAIT) && imem_valid_i));
    end

    // Next-state logic for the FSM, pc and FIFO bookkeeping; redirect wins.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (br_taken_i) begin
            pc_d     = taddr_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            // A read still in flight must be drained. If its response lands
            // in this very cycle it is simply dropped, which also lets a
            // repeated redirect while draining finish instead of waiting on
            // a response that has already gone by.
            if ((state_q != ST_IDLE) && !imem_valid_i) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE:  if (w_issue) state_d = ST_WAIT;
                ST_WAIT:  if (imem_valid_i) state_d = w_issue ? ST_WAIT : ST_IDLE;
                ST_DRAIN: if (imem_valid_i) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
            if (w_issue) begin
                pc_d     = pc_q + c_addr_one;
                req_pc_d = pc_q;
            end
            if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_one;
            if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + c_cnt_one;
                2'b01:   count_d = count_q - c_cnt_one;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observed through valid-gated outputs.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    // Flag a push into a full FIFO; the slot reservation should prevent it.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            assert (!(w_push && (count_q == c_full)))
                else $error("fetch_prefetch_unit: push into full prefetch FIFO");
        end
    end

    // Outputs: memory request, pc pair and the registered FIFO head.
    always_comb begin
        instrmem_rd_o = w_issue;
        imem_addr_o   = pc_q;
        pc_o          = pc_q;
        npc_o         = pc_q + c_addr_one;
        dout_valid_o  = w_dout_valid;
        dout_instr_o  = w_dout_valid ? fifo_instr_q[rd_ptr_q] : '0;
        dout_pc_o     = w_dout_valid ? fifo_pc_q[rd_ptr_q] : '0;
        dout_npc_o    = w_dout_valid ? (fifo_pc_q[rd_ptr_q] + c_addr_one) : '0;
        fifo_count_o  = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_prefetch_unit
//  Description : Directed self-checking bench for fetch_prefetch_unit with a
//                variable-latency instruction memory model (data = addr^C3C3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_unit;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        en_f       = 1'b0;
    logic        en_u       = 1'b0;
    logic        br         = 1'b0;
    logic [15:0] taddr      = '0;
    logic        instrmem_rd;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic [15:0] pc;
    logic [15:0] npc;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [15:0] dout_instr;
    logic [15:0] dout_pc;
    logic [15:0] dout_npc;
    logic [2:0]  fifo_count;

    int          n_vec = 0;
    int          n_err = 0;

    logic        mem_kill = 1'b0;
    int          mem_lat  = 1;
    bit          mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [15:0] mem_addr = '0;

    fetch_prefetch_unit dut (
        .clock_i           (clk),
        .reset_i           (rst),
        .enable_fetch_i    (en_f),
        .enable_updatePC_i (en_u),
        .br_taken_i        (br),
        .taddr_i           (taddr),
        .instrmem_rd_o     (instrmem_rd),
        .imem_addr_o       (imem_addr),
        .imem_valid_i      (imem_valid),
        .imem_rdata_i      (imem_rdata),
        .pc_o              (pc),
        .npc_o             (npc),
        .dout_valid_o      (dout_valid),
        .dout_ready_i      (dout_ready),
        .dout_instr_o      (dout_instr),
        .dout_pc_o         (dout_pc),
        .dout_npc_o        (dout_npc),
        .fifo_count_o      (fifo_count)
    );

    always #5 clk = ~clk;

    // Memory model: response valid mem_lat cycles after the request edge.
    always @(negedge clk) begin
        if (mem_kill) begin
            mem_pend   = 1'b0;
            imem_valid = 1'b0;
        end else if (mem_pend) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem_addr ^ 16'hC3C3;
                mem_pend   = 1'b0;
            end else begin
                imem_valid = 1'b0;
            end
        end else begin
            imem_valid = 1'b0;
        end
        #1;
        if (!mem_kill && instrmem_rd) begin
            mem_pend = 1'b1;
            mem_cnt  = mem_lat;
            mem_addr = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        rst      = 1'b1;
        mem_kill = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        mem_kill = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        en_f = 1'b1; en_u = 1'b1; dout_ready = 1'b1; br = 1'b0;
        rst = 1'b1; mem_kill = 1'b1;
        smp();
        n_vec++; if (pc !== 16'h3000) begin n_err++; $display("FAIL reset_pc: got %h want 3000", pc); end
        n_vec++; if (npc !== 16'h3001) begin n_err++; $display("FAIL reset_npc: got %h want 3001", npc); end
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", instrmem_rd); end
        n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid: got %b want 0", dout_valid); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_vec++; if (dout_pc !== 16'h0000) begin n_err++; $display("FAIL reset_dpc: got %h want 0000", dout_pc); end
        n_vec++; if (dout_instr !== 16'h0000) begin n_err++; $display("FAIL reset_dinstr: got %h want 0000", dout_instr); end
        n_vec++; if (dout_npc !== 16'h0000) begin n_err++; $display("FAIL reset_dnpc: got %h want 0000", dout_npc); end
    endtask

    task automatic test_stream();
        logic [15:0] e;
        en_f = 1'b1; en_u = 1'b1; dout_ready = 1'b1; br = 1'b0; mem_lat = 1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            smp();
            e = 16'h3000 + 16'(i);
            n_vec++; if (instrmem_rd !== 1'b1) begin n_err++; $display("FAIL stream_rd[%0d]: got %b want 1", i, instrmem_rd); end
            n_vec++; if (imem_addr !== e) begin n_err++; $display("FAIL stream_addr[%0d]: got %h want %h", i, imem_addr, e); end
            if (i >= 2) begin
                e = 16'h3000 + 16'(i - 2);
                n_vec++; if (dout_pc !== e) begin n_err++; $display("FAIL stream_dpc[%0d]: got %h want %h", i, dout_pc, e); end
                n_vec++; if (dout_instr !== (e ^ 16'hC3C3)) begin n_err++; $display("FAIL stream_dinstr[%0d]: got %h want %h", i, dout_instr, e ^ 16'hC3C3); end
                n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want 1", i, fifo_count); end
            end else begin
                n_vec++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL stream_dvalid[%0d]: got %b want 0", i, dout_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e;
        en_f = 1'b1; en_u = 1'b1; dout_ready = 1'b0; br = 1'b0; mem_lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            smp();
            e = 16'h3000 + 16'(i);
            n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== e) begin n_err++; $display("FAIL bp_issue[%0d]: got rd=%b addr=%h want rd=1 addr=%h", i, instrmem_rd, imem_addr, e); end
            tick();
        end
        smp();
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL bp_noissue_last: got %b want 0", instrmem_rd); end
        tick();
        for (int i = 0; i < 4; i++) begin
            smp();
            n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL bp_full_rd[%0d]: got %b want 0", i, instrmem_rd); end
            n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL bp_full_count[%0d]: got %0d want 4", i, fifo_count); end
            n_vec++; if (pc !== 16'h3004) begin n_err++; $display("FAIL bp_full_pc[%0d]: got %h want 3004", i, pc); end
            n_vec++; if (dout_pc !== 16'h3000) begin n_err++; $display("FAIL bp_full_dpc[%0d]: got %h want 3000", i, dout_pc); end
            tick();
        end
        dout_ready = 1'b1;
        smp();
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3004) begin n_err++; $display("FAIL bp_resume: got rd=%b addr=%h want rd=1 addr=3004", instrmem_rd, imem_addr); end
        tick();
        smp();
        n_vec++; if (dout_pc !== 16'h3001) begin n_err++; $display("FAIL bp_resume_dpc: got %h want 3001", dout_pc); end
        n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL bp_resume_count: got %0d want 3", fifo_count); end
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3005) begin n_err++; $display("FAIL bp_resume_next: got rd=%b addr=%h want rd=1 addr=3005", instrmem_rd, imem_addr); end
    endtask

    task automatic test_redirect_drain();
        en_f = 1'b1; en_u = 1'b1; dout_ready = 1'b0; br = 1'b0; mem_lat = 3;
        do_reset();
        smp();
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3000) begin n_err++; $display("FAIL drain_first: got rd=%b addr=%h want rd=1 addr=3000", instrmem_rd, imem_addr); end
        tick(); smp();
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL drain_wait1: got %b want 0", instrmem_rd); end
        tick(); smp(); tick(); smp();
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3001) begin n_err++; $display("FAIL drain_second: got rd=%b addr=%h want rd=1 addr=3001", instrmem_rd, imem_addr); end
        tick();
        br = 1'b1; taddr = 16'h3100;
        smp();
        n_vec++; if (fifo_count !== 3'd1 || dout_pc !== 16'h3000) begin n_err++; $display("FAIL drain_prebr: got count=%0d dpc=%h want count=1 dpc=3000", fifo_count, dout_pc); end
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL drain_br_rd: got %b want 0", instrmem_rd); end
        tick();
        br = 1'b0;
        smp();
        n_vec++; if (fifo_count !== 3'd0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL drain_flush: got count=%0d dvalid=%b want 0 0", fifo_count, dout_valid); end
        n_vec++; if (pc !== 16'h3100) begin n_err++; $display("FAIL drain_pc: got %h want 3100", pc); end
        tick(); smp();
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL drain_drop_rd: got %b want 0", instrmem_rd); end
        tick(); smp();
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3100) begin n_err++; $display("FAIL drain_target: got rd=%b addr=%h want rd=1 addr=3100", instrmem_rd, imem_addr); end
        n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_stale_count: got %0d want 0", fifo_count); end
        tick(); smp(); tick(); smp(); tick(); smp();
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3101) begin n_err++; $display("FAIL drain_target_next: got rd=%b addr=%h want rd=1 addr=3101", instrmem_rd, imem_addr); end
        tick(); smp();
        n_vec++; if (dout_valid !== 1'b1 || dout_pc !== 16'h3100) begin n_err++; $display("FAIL drain_dpc: got valid=%b dpc=%h want 1 3100", dout_valid, dout_pc); end
        n_vec++; if (dout_instr !== (16'h3100 ^ 16'hC3C3)) begin n_err++; $display("FAIL drain_dinstr: got %h want %h", dout_instr, 16'h3100 ^ 16'hC3C3); end
    endtask

    task automatic test_redirect_collision();
        en_f = 1'b1; en_u = 1'b1; dout_ready = 1'b1; br = 1'b0; mem_lat = 1;
        do_reset();
        smp(); tick(); smp(); tick(); smp(); tick();
        br = 1'b1; taddr = 16'h3200;
        smp();
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL coll_rd: got %b want 0", instrmem_rd); end
        n_vec++; if (dout_valid !== 1'b1 || dout_pc !== 16'h3001) begin n_err++; $display("FAIL coll_head: got valid=%b dpc=%h want 1 3001", dout_valid, dout_pc); end
        tick();
        br = 1'b0;
        smp();
        n_vec++; if (fifo_count !== 3'd0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL coll_flush: got count=%0d dvalid=%b want 0 0", fifo_count, dout_valid); end
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3200) begin n_err++; $display("FAIL coll_target: got rd=%b addr=%h want rd=1 addr=3200", instrmem_rd, imem_addr); end
        tick(); smp();
        n_vec++; if (fifo_count !== 3'd0 || imem_addr !== 16'h3201) begin n_err++; $display("FAIL coll_next: got count=%0d addr=%h want 0 3201", fifo_count, imem_addr); end
        tick(); smp();
        n_vec++; if (dout_pc !== 16'h3200 || fifo_count !== 3'd1) begin n_err++; $display("FAIL coll_dpc: got dpc=%h count=%0d want 3200 1", dout_pc, fifo_count); end
    endtask

    task automatic test_wrap();
        en_f = 1'b0; en_u = 1'b0; dout_ready = 1'b0; br = 1'b0; mem_lat = 1;
        do_reset();
        br = 1'b1; taddr = 16'hFFFF;
        smp();
        n_vec++; if (instrmem_rd !== 1'b0) begin n_err++; $display("FAIL wrap_disabled_rd: got %b want 0", instrmem_rd); end
        tick();
        br = 1'b0; en_f = 1'b1; en_u = 1'b1;
        smp();
        n_vec++; if (pc !== 16'hFFFF || npc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got pc=%h npc=%h want FFFF 0000", pc, npc); end
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'hFFFF) begin n_err++; $display("FAIL wrap_issue: got rd=%b addr=%h want rd=1 addr=FFFF", instrmem_rd, imem_addr); end
        tick(); smp();
        n_vec++; if (pc !== 16'h0000 || npc !== 16'h0001) begin n_err++; $display("FAIL wrap_pc_next: got pc=%h npc=%h want 0000 0001", pc, npc); end
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h0000) begin n_err++; $display("FAIL wrap_issue_next: got rd=%b addr=%h want rd=1 addr=0000", instrmem_rd, imem_addr); end
        tick(); smp();
        n_vec++; if (dout_pc !== 16'hFFFF || dout_npc !== 16'h0000) begin n_err++; $display("FAIL wrap_dout: got dpc=%h dnpc=%h want FFFF 0000", dout_pc, dout_npc); end
        n_vec++; if (dout_instr !== 16'h3C3C) begin n_err++; $display("FAIL wrap_dinstr: got %h want 3C3C", dout_instr); end
    endtask

    task automatic test_reset_mid_wait();
        en_f = 1'b1; en_u = 1'b1; dout_ready = 1'b1; br = 1'b0; mem_lat = 3;
        do_reset();
        smp();
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3000) begin n_err++; $display("FAIL rmw_issue: got rd=%b addr=%h want rd=1 addr=3000", instrmem_rd, imem_addr); end
        tick(); smp();
        n_vec++; if (pc !== 16'h3001) begin n_err++; $display("FAIL rmw_pre_pc: got %h want 3001", pc); end
        #1;
        rst = 1'b1;
        #1;
        n_vec++; if (pc !== 16'h3000 || npc !== 16'h3001) begin n_err++; $display("FAIL rmw_async_pc: got pc=%h npc=%h want 3000 3001", pc, npc); end
        n_vec++; if (instrmem_rd !== 1'b0 || dout_valid !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL rmw_async_out: got rd=%b dvalid=%b count=%0d want 0 0 0", instrmem_rd, dout_valid, fifo_count); end
        tick(); tick();
        rst = 1'b0; en_f = 1'b0;
        smp();
        n_vec++; if (instrmem_rd !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL rmw_stale_cycle: got rd=%b count=%0d want 0 0", instrmem_rd, fifo_count); end
        tick();
        en_f = 1'b1;
        smp();
        n_vec++; if (fifo_count !== 3'd0 || dout_valid !== 1'b0) begin n_err++; $display("FAIL rmw_stale_dropped: got count=%0d dvalid=%b want 0 0", fifo_count, dout_valid); end
        n_vec++; if (instrmem_rd !== 1'b1 || imem_addr !== 16'h3000) begin n_err++; $display("FAIL rmw_restart: got rd=%b addr=%h want rd=1 addr=3000", instrmem_rd, imem_addr); end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_collision();
        test_wrap();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
